sfq_and_cell: RTL and testbench
===============================

Name: sfq_and_cell

Overview:
- Synchronous digital model of an MIT-LL RSFQ clocked AND cell.
- Three toggle-encoded pulse inputs: a, b and the SFQ clock sfq_clk. Every level change on one of them is one SFQ pulse.
- Data pulses are latched between SFQ clock pulses. An SFQ clock pulse fires the output only if both a and b arrived since the previous SFQ clock pulse.
- Used as a reference/emulation cell in SFQ netlist co-simulation and assertion flows; runs entirely on one system clock.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer; legal values 2..4.

Ports:
- clk, input, 1, system clock; all state updates occur on its rising edge.
- rst_n, input, 1, asynchronous active-low reset; deassertion is synchronised internally.
- a, input, 1, toggle-encoded data pulse A (asynchronous to clk).
- b, input, 1, toggle-encoded data pulse B (asynchronous to clk).
- sfq_clk, input, 1, toggle-encoded SFQ clock pulse (asynchronous to clk).
- out, output, 1, toggle-encoded result; changes level once per firing.
- out_pulse, output, 1, one-cycle strobe in the same cycle out changes.
- err_a, output, 1, one-cycle strobe: A pulse arrived while A already stored.
- err_b, output, 1, one-cycle strobe: B pulse arrived while B already stored.
- state, output, 2, current cell state for debug (encoding below).

Behaviour:
- Reset (rst_n low, async):
  - out=0, out_pulse=0, err_a=0, err_b=0, state=S0.
  - All synchronizer flops and previous-level registers = 0, so inputs are expected low at reset.
- Pulse detection, per input:
  - SYNC_STAGES-flop synchronizer, then compare against the previous synchronized level.
  - A difference is one pulse event (pa, pb, pc) for one clk cycle.
  - Pulses closer together than SYNC_STAGES+1 clk periods on the same input are not guaranteed to be resolved; this is the caller's constraint.
- States (2-bit): S0=00 empty, S1=01 A stored, S2=10 B stored, S3=11 A and B stored.
- Data transitions when pc=0:
  - pa: S0->S1, S2->S3.
  - pa in S1 or S3: state unchanged, err_a=1 for one cycle (error state, pulse absorbed, not fired).
  - pb: S0->S2, S1->S3.
  - pb in S2 or S3: state unchanged, err_b=1.
  - pa and pb in the same cycle: both applied, e.g. S0->S3, S1->S3 with err_a.
- Clock transitions (pc=1):
  - Evaluated against the state held before this cycle.
  - If state==S3: out toggles and out_pulse=1.
  - Cell always clears; next state = S0 updated with any same-cycle pa/pb, i.e. same-cycle data belongs to the next SFQ period.
  - Clocking in S0, S1 or S2 clears silently: no output, no error.
- Latency: from an input level change meeting setup on clk edge k to the registered response (out/out_pulse/err/state) is edge k+SYNC_STAGES (3 edges incl. k for default).
- Outputs are registered; no combinational path from inputs to outputs.
- Reset mid-operation discards stored data and does not toggle out.

Decomposition:
- Package sfq_and_pkg: enum typedef sfq_and_state_t {S0,S1,S2,S3} with the 2-bit encoding above.
- Sub-module sfq_pulse_detect (synchronizer + toggle-edge detector, parameter SYNC_STAGES), instantiated three times for a, b, sfq_clk.
- Top contains the state machine and output registers.

Test Plan:
- Reset, all inputs 0: after release out=0, state=00, no strobes for 20 cycles.
- Toggle a, toggle a again, toggle b, toggle sfq_clk, each 10 cycles apart:
  - state 01, then err_a strobe with state 01, then 11.
  - Clock: out 0->1 with out_pulse, state 00.
- Then toggle b, toggle a, no clock: state 10 then 11; out stays 1. Next sfq_clk: out 1->0.
- Toggle b twice then sfq_clk: err_b strobe; clock clears to 00; out unchanged.
- a and b toggle in same cycle as sfq_clk while in S0: no fire; state becomes 11. Next sfq_clk: out toggles.
- Assert rst_n low while in S3, then release and toggle sfq_clk: state 00, out stays 0, no out_pulse.

Source files
------------

// File: rtl/sfq_and_pkg.sv
// Shared types for the clocked RSFQ AND cell model.
package sfq_and_pkg;

    // Bit 0 = A stored, bit 1 = B stored.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } sfq_and_state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Pack the stored-data flags {B, A} into a state value.
    function automatic sfq_and_state_t pack_state(input logic i_b, input logic i_a);
        return sfq_and_state_t'({i_b, i_a});
    endfunction

endpackage

// File: rtl/sfq_pulse_detect.sv
// Synchronizer plus toggle-edge detector: any level change on i_lvl
// becomes a single-cycle o_pulse after the synchronizer delay.
module sfq_pulse_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lvl,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the async level through the synchronizer and remember the last settled level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_lvl};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pulse = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/sfq_and_cell.sv
// Clocked RSFQ AND cell: latches A/B pulses between SFQ clock pulses and
// fires a toggle on out when both were present at the clock pulse.
module sfq_and_cell
    import sfq_and_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // legal range SYNC_STAGES_MIN..SYNC_STAGES_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       sfq_clk,
    output logic       out,
    output logic       out_pulse,
    output logic       err_a,
    output logic       err_b,
    output logic [1:0] state
);

    logic [1:0]     r_rst_sync;
    logic           w_rst_n;
    logic           w_pa, w_pb, w_pc;
    sfq_and_state_t r_state, w_state_nxt;
    logic           w_fire, w_err_a, w_err_b;
    logic           r_out, r_out_pulse, r_err_a, r_err_b;

    // Reset asserts immediately but releases synchronously to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    sfq_pulse_detect #(.SYNC_STAGES(SYNC_STAGES)) u_det_a (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_lvl(a), .o_pulse(w_pa)
    );
    sfq_pulse_detect #(.SYNC_STAGES(SYNC_STAGES)) u_det_b (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_lvl(b), .o_pulse(w_pb)
    );
    sfq_pulse_detect #(.SYNC_STAGES(SYNC_STAGES)) u_det_c (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_lvl(sfq_clk), .o_pulse(w_pc)
    );

    // State register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S0;
        else          r_state <= w_state_nxt;
    end

    // Next state: a clock pulse empties the cell and same-cycle data starts
    // the next period; otherwise data pulses OR into the stored flags
    // (a repeat pulse is absorbed, leaving the state as is).
    always_comb begin
        w_state_nxt = r_state;
        if (w_pc) w_state_nxt = pack_state(w_pb, w_pa);
        else      w_state_nxt = pack_state(w_pb | r_state[1], w_pa | r_state[0]);
    end

    // Output decode against the state held before this cycle.
    always_comb begin
        w_fire  = w_pc && (r_state == S3);
        w_err_a = !w_pc && w_pa && r_state[0];
        w_err_b = !w_pc && w_pb && r_state[1];
    end

    // Registered outputs: out toggles once per firing, strobes last one cycle.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_out       <= 1'b0;
            r_out_pulse <= 1'b0;
            r_err_a     <= 1'b0;
            r_err_b     <= 1'b0;
        end else begin
            r_out       <= r_out ^ w_fire;
            r_out_pulse <= w_fire;
            r_err_a     <= w_err_a;
            r_err_b     <= w_err_b;
        end
    end

    assign out       = r_out;
    assign out_pulse = r_out_pulse;
    assign err_a     = r_err_a;
    assign err_b     = r_err_b;
    assign state     = r_state;

endmodule

// File: tb/tb_sfq_and_cell.sv
// Self-checking bench for sfq_and_cell: directed table, exact-latency and
// reset sequences, then random pulse traffic against a behavioural model.
module tb_sfq_and_cell;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a = 1'b0, b = 1'b0, sfq_clk = 1'b0;
    logic       out, out_pulse, err_a, err_b;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // strobe counts observed on the DUT
    int   cnt_op = 0, cnt_ea = 0, cnt_eb = 0;
    logic out_q  = 1'b0;

    // behavioural model: stored flags, output level, expected strobe counts
    bit m_a = 0, m_b = 0, m_out = 0;
    int m_op = 0, m_ea = 0, m_eb = 0;

    typedef struct {
        bit         ta, tb, tc;
        logic [1:0] st;
        bit         o;
        int         ea, eb, op;
    } vec_t;

    vec_t tbl[12];

    sfq_and_cell #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sfq_clk(sfq_clk),
        .out(out), .out_pulse(out_pulse), .err_a(err_a), .err_b(err_b),
        .state(state)
    );

    always #5 clk = ~clk;

    // Count strobes and check out_pulse coincides with every out change.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_pulse === 1'b1) cnt_op++;
            if (err_a === 1'b1)     cnt_ea++;
            if (err_b === 1'b1)     cnt_eb++;
            n_cmp++;
            if (out_pulse !== (out !== out_q)) begin
                n_bad++;
                $display("FAIL pulse_align: out_pulse=%b out=%b prev_out=%b", out_pulse, out, out_q);
            end
        end
        out_q = out;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [1:0] es, input bit eo,
                       input int eea, input int eeb, input int eop);
        cmp({nm, ".state"}, {30'd0, state}, {30'd0, es});
        cmp({nm, ".out"},   {31'd0, out},   {31'd0, eo});
        cmp({nm, ".err_a_cnt"},     cnt_ea, eea);
        cmp({nm, ".err_b_cnt"},     cnt_eb, eeb);
        cmp({nm, ".out_pulse_cnt"}, cnt_op, eop);
    endtask

    task automatic chk_model(input string nm);
        chk(nm, {m_b, m_a}, m_out, m_ea, m_eb, m_op);
    endtask

    // Cell rules at pulse level: clock fires if both stored, then the
    // period restarts with whatever data arrived alongside the clock.
    function automatic void model_apply(input bit ta, input bit tb, input bit tc);
        if (tc) begin
            if (m_a && m_b) begin
                m_out = !m_out;
                m_op++;
            end
            m_a = ta;
            m_b = tb;
        end else begin
            if (ta) begin if (m_a) m_ea++; else m_a = 1; end
            if (tb) begin if (m_b) m_eb++; else m_b = 1; end
        end
    endfunction

    // Toggle the selected inputs together, then let the cell settle.
    task automatic ev(input bit ta, input bit tb, input bit tc);
        @(negedge clk); #1;
        if (ta) a = ~a;
        if (tb) b = ~b;
        if (tc) sfq_clk = ~sfq_clk;
        model_apply(ta, tb, tc);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        //            ta tb tc  st    o  ea eb op
        tbl[0]  = '{1, 0, 0, 2'b01, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 2'b01, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 0, 2'b11, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 2'b00, 1, 1, 0, 1};
        tbl[4]  = '{0, 1, 0, 2'b10, 1, 1, 0, 1};
        tbl[5]  = '{1, 0, 0, 2'b11, 1, 1, 0, 1};
        tbl[6]  = '{0, 0, 1, 2'b00, 0, 1, 0, 2};
        tbl[7]  = '{0, 1, 0, 2'b10, 0, 1, 0, 2};
        tbl[8]  = '{0, 1, 0, 2'b10, 0, 1, 1, 2};
        tbl[9]  = '{0, 0, 1, 2'b00, 0, 1, 1, 2};
        tbl[10] = '{1, 1, 1, 2'b11, 0, 1, 1, 2};
        tbl[11] = '{0, 0, 1, 2'b00, 1, 1, 1, 3};

        // reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("in_reset", 2'b00, 1'b0, 0, 0, 0);
        cmp("in_reset.strobes", {29'd0, out_pulse, err_a, err_b}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (20) step();
        chk("post_reset", 2'b00, 1'b0, 0, 0, 0);

        // directed table
        for (int i = 0; i < 12; i++) begin
            ev(tbl[i].ta, tbl[i].tb, tbl[i].tc);
            chk($sformatf("tbl%0d", i), tbl[i].st, tbl[i].o, tbl[i].ea, tbl[i].eb, tbl[i].op);
        end

        // exact latency: change before edge k, response at edge k+2
        @(negedge clk); #1;
        a = ~a;
        model_apply(1, 0, 0);
        step(); cmp("lat_a.k",   {30'd0, state}, 32'd0);
        step(); cmp("lat_a.k1",  {30'd0, state}, 32'd0);
        step(); cmp("lat_a.k2",  {30'd0, state}, 32'd1);
        repeat (6) step();
        ev(0, 1, 0);
        chk_model("pre_fire");
        @(negedge clk); #1;
        sfq_clk = ~sfq_clk;
        model_apply(0, 0, 1);
        step(); cmp("lat_c.k.pulse",  {31'd0, out_pulse}, 32'd0);
        step(); cmp("lat_c.k1.pulse", {31'd0, out_pulse}, 32'd0);
        step(); cmp("lat_c.k2.pulse", {31'd0, out_pulse}, 32'd1);
                cmp("lat_c.k2.out",   {31'd0, out},       32'd0);
        step(); cmp("lat_c.k3.pulse", {31'd0, out_pulse}, 32'd0);
                cmp("lat_c.k3.state", {30'd0, state},     32'd0);
        repeat (5) step();
        chk_model("post_fire");

        // reset mid-operation while holding A and B with out high
        ev(1, 1, 0);
        ev(0, 0, 1);
        ev(1, 0, 0);
        ev(0, 1, 0);
        chk_model("pre_rst");
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        cmp("mid_rst.state", {30'd0, state}, 32'd0);
        cmp("mid_rst.out",   {31'd0, out},   32'd0);
        a = 1'b0; b = 1'b0; sfq_clk = 1'b0;
        m_a = 0; m_b = 0; m_out = 0;
        repeat (3) step();
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (5) step();
        ev(0, 0, 1);
        chk("rst_then_clk", 2'b00, 1'b0, m_ea, m_eb, m_op);
        chk_model("rst_then_clk_model");

        // random traffic against the model
        for (int i = 0; i < 80; i++) begin
            bit ta, tb, tc;
            ta = ($urandom_range(0, 2) != 0);
            tb = ($urandom_range(0, 2) != 0);
            tc = ($urandom_range(0, 3) == 0);
            ev(ta, tb, tc);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
